// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed seven-segment display.
// Steps the digit index at a programmable rate; buffered data is committed only at frame boundaries.
module seg_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int GHOST_CYC = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    output logic        ready,
    input  logic [31:0] data_in,
    input  logic [7:0]  mask_in,
    output logic [2:0]  sel,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    idx_reg, idx_next;
    logic [31:0]   active_data_reg, active_data_next;
    logic [7:0]    active_mask_reg, active_mask_next;
    logic [31:0]   pend_data_reg, pend_data_next;
    logic [7:0]    pend_mask_reg, pend_mask_next;
    logic          pend_valid_reg, pend_valid_next;
    logic          frame_done_reg, frame_done_next;

    logic          tick;
    logic          fb;
    logic          in_ghost;
    logic [3:0]    nib [8];

    assign tick = (cnt_reg == CNT_MAX);
    assign fb   = tick && (idx_reg == 3'd7);

    always_comb begin
        cnt_next         = tick ? '0 : cnt_reg + 1'b1;
        idx_next         = tick ? idx_reg + 3'd1 : idx_reg;
        frame_done_next  = fb;
        active_data_next = active_data_reg;
        active_mask_next = active_mask_reg;
        pend_data_next   = pend_data_reg;
        pend_mask_next   = pend_mask_reg;
        pend_valid_next  = pend_valid_reg;
        if (fb) begin
            // Boundary: a buffered word wins; an empty buffer lets a same-cycle load bypass it.
            if (pend_valid_reg) begin
                active_data_next = pend_data_reg;
                active_mask_next = pend_mask_reg;
                pend_valid_next  = 1'b0;
            end else if (load) begin
                active_data_next = data_in;
                active_mask_next = mask_in;
            end
        end else if (load && !pend_valid_reg) begin
            pend_data_next  = data_in;
            pend_mask_next  = mask_in;
            pend_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg         <= '0;
            idx_reg         <= 3'd0;
            active_data_reg <= 32'd0;
            active_mask_reg <= 8'hFF;
            pend_data_reg   <= 32'd0;
            pend_mask_reg   <= 8'd0;
            pend_valid_reg  <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            idx_reg         <= idx_next;
            active_data_reg <= active_data_next;
            active_mask_reg <= active_mask_next;
            pend_data_reg   <= pend_data_next;
            pend_mask_reg   <= pend_mask_next;
            pend_valid_reg  <= pend_valid_next;
            frame_done_reg  <= frame_done_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nib
            assign nib[gi] = active_data_reg[4*gi +: 4];
        end
        if (GHOST_CYC == 0) begin : g_no_ghost
            assign in_ghost = 1'b0;
        end else begin : g_ghost
            assign in_ghost = (cnt_reg < CW'(GHOST_CYC));
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        seg = 7'h00;
        if (!in_ghost && !active_mask_reg[idx_reg])
            seg = hex7(nib[idx_reg]);
    end

    assign sel        = idx_reg;
    assign ready      = !pend_valid_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a cycle-count model of the scan timing and commit rules,
// compared every cycle, plus directed checks with hand-computed values.
module tb_seg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int GHOST = 1;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic [7:0]  mask_in = 8'd0;
    logic        ready;
    logic [2:0]  sel;
    logic [6:0]  seg;
    logic        frame_done;

    int total = 0;
    int bad = 0;

    seg_scan_ctrl #(.CLK_DIV(DIV), .GHOST_CYC(GHOST)) dut (
        .clk(clk),
        .resetn(resetn),
        .load(load),
        .ready(ready),
        .data_in(data_in),
        .mask_in(mask_in),
        .sel(sel),
        .seg(seg),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: m_t = clock edges since reset release; position in the frame follows arithmetically.
    int          m_t = 0;
    logic [31:0] m_data = 32'd0;
    logic [7:0]  m_mask = 8'hFF;
    logic [31:0] m_pdata = 32'd0;
    logic [7:0]  m_pmask = 8'd0;
    logic        m_pv = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_t    <= 0;
            m_data <= 32'd0;
            m_mask <= 8'hFF;
            m_pv   <= 1'b0;
        end else begin
            m_t <= m_t + 1;
            if (m_t % FRAME == FRAME - 1) begin
                if (m_pv) begin
                    m_data <= m_pdata;
                    m_mask <= m_pmask;
                    m_pv   <= 1'b0;
                end else if (load) begin
                    m_data <= data_in;
                    m_mask <= mask_in;
                end
            end else if (load && !m_pv) begin
                m_pdata <= data_in;
                m_pmask <= mask_in;
                m_pv    <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    always @(negedge clk) begin
        int i;
        logic [6:0] e_seg;
        i = (m_t / DIV) % 8;
        e_seg = 7'h00;
        if ((m_t % DIV) >= GHOST && !m_mask[i])
            e_seg = hex_tab[m_data[4*i +: 4]];
        chk("model_sel", 32'(sel), 32'(i));
        chk("model_seg", 32'(seg), 32'(e_seg));
        chk("model_ready", 32'(ready), 32'(!m_pv));
        chk("model_frame_done", 32'(frame_done), 32'(m_t > 0 && m_t % FRAME == 0));
    end

    task automatic wait_slot(input int d, input int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((m_t % FRAME) != d * DIV + c && n < 2 * FRAME);
        if ((m_t % FRAME) != d * DIV + c) begin
            total++;
            bad++;
            $display("FAIL wait_slot: digit %0d cnt %0d not reached", d, c);
        end
    endtask

    task automatic pulse_load(input logic [31:0] d, input logic [7:0] m);
        load = 1'b1;
        data_in = d;
        mask_in = m;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int pulses;
        int last_t;
        repeat (2) @(negedge clk);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_seg", 32'(seg), 0);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_frame_done", 32'(frame_done), 0);
        resetn = 1'b1;

        // Scan stepping
        wait_slot(1, 0);  chk("step_sel1", 32'(sel), 1);
        wait_slot(7, 0);  chk("step_sel7", 32'(sel), 7);
        wait_slot(0, 0);  chk("step_wrap", 32'(sel), 0);

        // Display
        wait_slot(2, 0);
        pulse_load(32'h76543210, 8'h00);
        chk("disp_ready_fall", 32'(ready), 0);
        wait_slot(7, 3);  chk("disp_ready_hold", 32'(ready), 0);
                          chk("disp_old_seg", 32'(seg), 0);
        wait_slot(0, 0);  chk("disp_ready_rise", 32'(ready), 1);
                          chk("disp_ghost", 32'(seg), 0);
        wait_slot(0, 1);  chk("disp_d0", 32'(seg), 32'h3F);
        wait_slot(3, 2);  chk("disp_d3", 32'(seg), 32'h4F);
        wait_slot(7, 1);  chk("disp_d7", 32'(seg), 32'h07);

        // Blanking
        wait_slot(1, 0);
        pulse_load(32'hFFFFFFFF, 8'hA5);
        wait_slot(0, 1);  chk("blank_d0", 32'(seg), 0);
        wait_slot(1, 0);  chk("blank_ghost_d1", 32'(seg), 0);
        wait_slot(1, 1);  chk("blank_d1", 32'(seg), 32'h71);
        wait_slot(2, 3);  chk("blank_d2", 32'(seg), 0);
        wait_slot(6, 2);  chk("blank_d6", 32'(seg), 32'h71);
        wait_slot(7, 1);  chk("blank_d7", 32'(seg), 0);

        // Busy drop
        wait_slot(2, 1);
        pulse_load(32'h89ABCDEF, 8'h00);
        chk("busy_ready", 32'(ready), 0);
        wait_slot(3, 1);
        pulse_load(32'h11111111, 8'h00);
        wait_slot(0, 1);  chk("busy_d0", 32'(seg), 32'h71);
        wait_slot(1, 1);  chk("busy_d1", 32'(seg), 32'h79);
        wait_slot(4, 2);  chk("busy_d4", 32'(seg), 32'h7C);

        // Bypass on the frame-boundary tick
        wait_slot(7, 3);  chk("byp_ready_before", 32'(ready), 1);
        pulse_load(32'h2468ACE0, 8'h00);
        chk("byp_ready_after", 32'(ready), 1);
        chk("byp_frame_done", 32'(frame_done), 1);
        wait_slot(0, 1);  chk("byp_d0", 32'(seg), 32'h3F);
        wait_slot(2, 1);  chk("byp_d2", 32'(seg), 32'h39);
                          chk("byp_ready_mid", 32'(ready), 1);

        // frame_done over three frames
        pulses = 0;
        last_t = -1;
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            if (frame_done) begin
                pulses++;
                chk("fd_sel", 32'(sel), 0);
                chk("fd_cnt", 32'(m_t % DIV), 0);
                if (last_t >= 0) chk("fd_spacing", 32'(m_t - last_t), FRAME);
                last_t = m_t;
            end
        end
        chk("fd_count", 32'(pulses), 3);

        // Reset while a load is pending
        wait_slot(4, 0);
        pulse_load(32'h55555555, 8'h00);
        wait_slot(5, 1);  chk("mr_pending", 32'(ready), 0);
                          chk("mr_seg_before", 32'(seg), 32'h7D);
        #2 resetn = 1'b0;
        #1;
        chk("mr_async_sel", 32'(sel), 0);
        chk("mr_async_seg", 32'(seg), 0);
        chk("mr_async_ready", 32'(ready), 1);
        chk("mr_async_frame_done", 32'(frame_done), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wait_slot(0, 1);  chk("mr_d0_after", 32'(seg), 0);
        wait_slot(5, 2);  chk("mr_d5_after", 32'(seg), 0);
        wait_slot(0, 0);  chk("mr_first_fd", 32'(frame_done), 1);
        wait_slot(3, 1);  chk("mr_d3_later", 32'(seg), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for the board's 8-digit multiplexed seven-segment display. It holds a 32-bit hex word (eight nibbles) with a per-digit blank mask and steps a digit index 0..7 at a programmable rate. The index drives the A2..A0 inputs of the 3-to-8 digit-select decoder directly downstream, and the block emits the matching active-high segment pattern. New display data is accepted through a single-entry buffer and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- CLK_DIV, 50000, clk cycles per digit slot; legal range 2..2^20
- GHOST_CYC, 2, leading cycles of each slot with segments forced off (anti-ghosting); legal range 0..CLK_DIV-1
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- load  in  1  request to accept data_in/mask_in
- ready  out  1  high when the buffer can accept a load
- data_in  in  32  nibble k = data_in[4k+3:4k] is shown on digit k
- mask_in  in  8  bit k=1 blanks digit k
- sel  out  3  current digit index; sel[2]/[1]/[0] go to decoder A2/A1/A0
- seg  out  7  segments a..g on seg[0]..seg[6], active-high
- frame_done  out  1  one-cycle pulse when the index wraps 7->0

## Operation
- Prescaler cnt counts 0..CLK_DIV-1 and then wraps to 0. tick = (cnt == CLK_DIV-1).
- On tick, idx increments modulo 8. sel = idx.
- Registers: active_data/active_mask (displayed), pend_data/pend_mask plus pend_valid (buffer). ready = !pend_valid.
- Frame boundary fb = tick && idx == 7.
- Load, non-boundary: if load && ready && !fb, pend <= inputs and pend_valid <= 1.
- load && !ready is ignored. No state change; the source holds load until ready.
- Commit at fb:
  - pend_valid=1: active <= pend, pend_valid <= 0.
  - pend_valid=0 && load: active <= inputs directly (bypass); pend_valid stays 0.
  - Otherwise active is unchanged.
- seg decode is combinational from the registers only (idx, cnt, active_*); there is no input-to-output combinational path.
  - seg = 0 if cnt < GHOST_CYC, or if active_mask[idx] = 1.
  - Otherwise seg = hex7(active_data nibble idx).
- hex7 table, 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- frame_done is a registered pulse: set on the clock edge where fb is true, cleared on the next edge.

## Timing
- Reset values:
  - cnt=0, idx=0, sel=0
  - active_data=0, active_mask=8'hFF, so seg=0
  - pend_valid=0, ready=1, frame_done=0
- Reset is asynchronous and acts immediately when asserted mid-frame. On release the first slot is digit 0 with cnt=0. Any pending load is lost.
- Each slot lasts exactly CLK_DIV cycles. A full frame is 8*CLK_DIV cycles.
- sel and seg change on the same edge. With GHOST_CYC>0, seg is 0 during the first GHOST_CYC cycles of every slot, including blanked and unblanked digits alike.
- Accepted load: ready falls on the next edge. It rises on the edge following the next fb.
- Worst-case latency from load to display: one frame plus one cycle.
- Bypass (load at fb with ready=1): the new data shows from digit 0 of the next frame, and ready stays high throughout.
- frame_done is high in the first cycle of each digit-0 slot, except the first slot after reset.
- Counter width is clog2(CLK_DIV). There is no overflow path.

## Test plan
- Reset: set CLK_DIV=4, GHOST_CYC=1, hold resetn low, then release. Required: sel=0, seg=0, ready=1, frame_done=0. sel then steps 0,1,...,7,0 every 4 cycles.
- Display: load data_in=32'h76543210, mask_in=0 mid-frame. Required:
  - ready falls one cycle later.
  - From the next digit-0 slot, seg per slot is 00 during cnt=0, then 3F,06,5B,4F,66,6D,7D,07 for digits 0..7.
  - ready rises on the cycle after the boundary.
- Blanking: load data_in=32'hFFFFFFFF, mask_in=8'hA5. Required: digits 0,2,5,7 give seg=0; digits 1,3,4,6 give seg=71 after the ghost cycle.
- Busy drop and bypass:
  - Load A, then assert load with B while ready=0. Required: B is ignored and A is shown.
  - Assert load with C exactly on the cycle of the idx=7/cnt=3 tick with ready=1. Required: C is shown from the next digit 0 and ready never falls.
- frame_done: over 3 frames, exactly 3 single-cycle pulses spaced 32 cycles apart, each coinciding with sel=0, cnt=0.
- Reset mid-operation: assert resetn low at idx=5 with pend_valid=1. Required:
  - All outputs return to reset values asynchronously, before the next clk edge.
  - After release, the pending data never appears and seg=0.
